spw_rx_packet_reader: RTL

- Host-side receive engine for the SpaceWire codec (SPW_TOP). It drains the codec RX FIFO (DATA_O / RD_DATA / RX_EMPTY), reassembles one packet at a time into an internal byte buffer, and records its length and terminator.
- It holds the completed packet for the host (Avalon PIO / NIOS/HPS side) until acknowledged.
- It is the read-side counterpart of the host path that pushes DATA_I / WR_DATA into the codec TX FIFO.

---
 rtl/spw_rx_packet_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spw_rx_packet_reader.sv
// spw_rx_packet_reader: drains the SpaceWire codec RX FIFO one character at a
// time, assembles a single packet into an internal byte buffer and holds it
// (length, terminator, truncation) until the host acknowledges it.
//
// Ports:
//   CLOCK, RESETn         clock, synchronous active-low reset
//   ENABLE                permits new RX FIFO reads
//   RX_EMPTY, DATA_O      codec RX FIFO status / output (valid cycle after RD_DATA)
//   RD_DATA               one-cycle read strobe to the RX FIFO (combinational)
//   PKT_READY             completed packet held in the buffer
//   PKT_LEN               stored data bytes (0..MAX_LEN)
//   PKT_EEP, PKT_TRUNC    terminator was EEP / packet overflowed the buffer
//   PKT_ACK               host releases the held packet
//   BUF_RD_ADDR/DATA      host buffer read port, 1-cycle registered latency
//   OVF_CNT               saturating count of truncated packets
module spw_rx_packet_reader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLOCK,
    input  logic              RESETn,
    input  logic              ENABLE,
    input  logic              RX_EMPTY,
    input  logic [8:0]        DATA_O,
    output logic              RD_DATA,
    output logic              PKT_READY,
    output logic [ADDR_W:0]   PKT_LEN,
    output logic              PKT_EEP,
    output logic              PKT_TRUNC,
    input  logic              PKT_ACK,
    input  logic [ADDR_W-1:0] BUF_RD_ADDR,
    output logic [7:0]        BUF_RD_DATA,
    output logic [7:0]        OVF_CNT
);

    localparam int unsigned MAX_LEN = 2 ** ADDR_W;
    localparam int unsigned LEN_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;       // doubles as the buffer write pointer
    logic               ready_q, ready_d;
    logic               eep_q, eep_d;
    logic               trunc_out_q, trunc_out_d;
    logic               trunc_q, trunc_d;   // overflow seen in the current packet
    logic [7:0]         ovf_q, ovf_d;
    logic [7:0]         rd_byte_q;
    logic               buf_we;
    logic [7:0]         buf_mem [MAX_LEN];

    wire is_ctrl  = DATA_O[8];
    // len_q never exceeds MAX_LEN, so its MSB alone says the buffer is full.
    wire buf_full = len_q[ADDR_W];

    // State and datapath registers.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ready_q     <= 1'b0;
            eep_q       <= 1'b0;
            trunc_out_q <= 1'b0;
            trunc_q     <= 1'b0;
            ovf_q       <= '0;
            rd_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ready_q     <= ready_d;
            eep_q       <= eep_d;
            trunc_out_q <= trunc_out_d;
            trunc_q     <= trunc_d;
            ovf_q       <= ovf_d;
            rd_byte_q   <= buf_mem[BUF_RD_ADDR];
        end
    end

    // Packet buffer write port; the read above sees the pre-write byte.
    always_ff @(posedge CLOCK) begin
        if (buf_we) begin
            buf_mem[len_q[ADDR_W-1:0]] <= DATA_O[7:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (ENABLE && !RX_EMPTY && !ready_q) state_d = S_WAIT;
            S_WAIT: state_d = is_ctrl ? S_HOLD : S_IDLE;
            S_HOLD: if (PKT_ACK) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath update logic.
    always_comb begin
        RD_DATA     = 1'b0;
        buf_we      = 1'b0;
        len_d       = len_q;
        ready_d     = ready_q;
        eep_d       = eep_q;
        trunc_out_d = trunc_out_q;
        trunc_d     = trunc_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                // Gated by RESETn so no FIFO character is popped and lost in reset.
                RD_DATA = RESETn && ENABLE && !RX_EMPTY && !ready_q;
            end
            S_WAIT: begin
                if (!is_ctrl) begin
                    if (!buf_full) begin
                        buf_we = 1'b1;
                        len_d  = len_q + LEN_W'(1);
                    end else begin
                        trunc_d = 1'b1;
                    end
                end else begin
                    eep_d       = (DATA_O[7:0] != 8'h00);
                    trunc_out_d = trunc_q;
                    ready_d     = 1'b1;
                    if (trunc_q && (ovf_q != 8'hFF)) begin
                        ovf_d = ovf_q + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                if (PKT_ACK) begin
                    len_d       = '0;
                    ready_d     = 1'b0;
                    eep_d       = 1'b0;
                    trunc_out_d = 1'b0;
                    trunc_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign PKT_READY   = ready_q;
    assign PKT_LEN     = len_q;
    assign PKT_EEP     = eep_q;
    assign PKT_TRUNC   = trunc_out_q;
    assign OVF_CNT     = ovf_q;
    assign BUF_RD_DATA = rd_byte_q;

endmodule
